// File: rtl/alu_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : alu_arbiter_if
// Description : Bundle between two requesters, the shared ALU and the
//               response consumer of alu_arbiter.
//               slave  modport : arbiter view (alu_arbiter uses this one)
//               master modport : environment view (requesters, ALU, sink)
//               Signals:
//                 req_valid/req_ready[1:0]   per-requester handshake
//                 req{0,1}_A/_B/_OP_Code     per-requester operands
//                 alu_A/_B/_OP_Code          registered drive to the ALU
//                 alu_Result/alu_NZCV        combinational ALU outputs
//                 rsp_valid/rsp_ready/rsp_id/rsp_Result/rsp_NZCV response
//                 flags_NZCV, busy           status
// Revision    : 1.0 - initial release
//============================================================================
interface alu_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_A;
    logic [DATA_W-1:0] req0_B;
    logic [OP_W-1:0]   req0_OP_Code;
    logic [DATA_W-1:0] req1_A;
    logic [DATA_W-1:0] req1_B;
    logic [OP_W-1:0]   req1_OP_Code;

    logic [DATA_W-1:0] alu_A;
    logic [DATA_W-1:0] alu_B;
    logic [OP_W-1:0]   alu_OP_Code;
    logic [DATA_W-1:0] alu_Result;
    logic [3:0]        alu_NZCV;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_Result;
    logic [3:0]        rsp_NZCV;
    logic [3:0]        flags_NZCV;
    logic              busy;

    modport slave (
        input  req_valid, req0_A, req0_B, req0_OP_Code,
               req1_A, req1_B, req1_OP_Code,
               alu_Result, alu_NZCV, rsp_ready,
        output req_ready, alu_A, alu_B, alu_OP_Code,
               rsp_valid, rsp_id, rsp_Result, rsp_NZCV, flags_NZCV, busy
    );

    modport master (
        output req_valid, req0_A, req0_B, req0_OP_Code,
               req1_A, req1_B, req1_OP_Code,
               alu_Result, alu_NZCV, rsp_ready,
        input  req_ready, alu_A, alu_B, alu_OP_Code,
               rsp_valid, rsp_id, rsp_Result, rsp_NZCV, flags_NZCV, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
//============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of a shared combinational
//               ALU. One operation in flight at a time:
//                 IDLE -> grant, latch operands  -> EXEC
//                 EXEC -> capture ALU result     -> RESP
//                 RESP -> hold response until rsp_ready -> IDLE
//               Arbitration is round-robin on ties (last_grant bit).
//               Optional macro ALU_ARB_FIXED_PRIO_EN gives requester 0
//               fixed priority on a tie; no last_grant bit exists then.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - alu_arbiter_if.slave (requests, ALU, response)
//               DATA_W/OP_W must match the interface instance parameters.
// Revision    : 1.0 - initial release
//============================================================================
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic              w_grant;
    logic              w_grant_id;

    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [OP_W-1:0]   r_op_code;
    logic              r_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic [3:0]        r_rsp_nzcv;
    logic [3:0]        r_flags_nzcv;

    logic [1:0]        w_req_ready;
    logic              w_rsp_valid;
    logic              w_busy;

    //------------------------------------------------------------------------
    // Arbitration
    //------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        // Requester 0 wins whenever it is asking.
        w_grant_id = ~bus.req_valid[0];
    end
`else
    logic r_last_grant;

    always_comb begin
        w_grant_id = 1'b0;
        if (&bus.req_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            // Single requester (or none): bit 1 set means requester 1.
            w_grant_id = bus.req_valid[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset value 1 makes requester 0 win the first tie.
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_grant_id;
        end
    end
`endif

    assign w_grant = (r_state == S_IDLE) && (|bus.req_valid);

    //------------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                // rsp_valid is high throughout RESP, so rsp_ready alone
                // completes the handshake; outside RESP it is ignored.
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_req_ready = 2'b00;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so the strobe is low while reset is held,
                // even if a requester keeps req_valid high.
                if (w_grant && rst_n) begin
                    w_req_ready[w_grant_id] = 1'b1;
                end
            end
            S_EXEC: begin
                w_busy = 1'b1;
            end
            S_RESP: begin
                w_busy      = 1'b1;
                w_rsp_valid = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Operand and response registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_code    <= '0;
            r_id         <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_nzcv   <= 4'h0;
            r_flags_nzcv <= 4'h0;
        end else begin
            if (w_grant) begin
                r_id <= w_grant_id;
                if (w_grant_id) begin
                    r_op_a    <= bus.req1_A;
                    r_op_b    <= bus.req1_B;
                    r_op_code <= bus.req1_OP_Code;
                end else begin
                    r_op_a    <= bus.req0_A;
                    r_op_b    <= bus.req0_B;
                    r_op_code <= bus.req0_OP_Code;
                end
            end
            // The ALU has had the whole EXEC cycle to settle on the
            // registered operands; sample its outputs on the closing edge.
            if (r_state == S_EXEC) begin
                r_rsp_result <= bus.alu_Result;
                r_rsp_nzcv   <= bus.alu_NZCV;
                r_flags_nzcv <= bus.alu_NZCV;
            end
        end
    end

    //------------------------------------------------------------------------
    // Output drive
    //------------------------------------------------------------------------
    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.busy        = w_busy;
    assign bus.alu_A       = r_op_a;
    assign bus.alu_B       = r_op_b;
    assign bus.alu_OP_Code = r_op_code;
    assign bus.rsp_id      = r_id;
    assign bus.rsp_Result  = r_rsp_result;
    assign bus.rsp_NZCV    = r_rsp_nzcv;
    assign bus.flags_NZCV  = r_flags_nzcv;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Two requester drivers,
//               a behavioural ALU, a transaction-level reference model and
//               a scoreboard monitor that compares every cycle in which the
//               DUT presents a strobe or a response.
//               Honours ALU_ARB_FIXED_PRIO_EN when defined.
// Revision    : 1.0 - initial release
//============================================================================
module tb_alu_arbiter;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic [3:0] nzcv;
    } exp_t;

    typedef struct {
        logic       id;
        logic [3:0] nzcv;
        logic [7:0] res;
    } act_t;

    logic       clk;
    logic       rst_n;
    logic       rr;
    logic       v_drv  [2];
    logic [7:0] a_drv  [2];
    logic [7:0] b_drv  [2];
    logic [2:0] op_drv [2];

    int   n_chk;
    int   n_fail;

    exp_t sb[$];
    act_t rsp_log[$];
    logic grant_log[$];

    logic m_pending;
    logic m_exec;
    logic m_last;

    alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: plain arithmetic on the operand values.
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        int   sum;
        logic [7:0] r;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                sum = int'(a) + int'(b);
                r   = sum[7:0];
                c   = sum > 255;
                v   = ($signed(a) + $signed(b) > 127) || ($signed(a) + $signed(b) < -128);
            end
            3'd1: begin
                sum = int'(a) - int'(b);
                r   = sum[7:0];
                c   = a >= b;
                v   = ($signed(a) - $signed(b) > 127) || ($signed(a) - $signed(b) < -128);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = ~a;
        endcase
        return {r[7], (r == 8'h00), c, v, r};
    endfunction

    function automatic logic winner(input logic [1:0] v, input logic last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return (v[0] == 1'b1) ? 1'b0 : (last | 1'b1);
`else
        if (v == 2'b11) return ~last;
        return v[1];
`endif
    endfunction

    assign bus.req_valid    = {v_drv[1], v_drv[0]};
    assign bus.req0_A       = a_drv[0];
    assign bus.req0_B       = b_drv[0];
    assign bus.req0_OP_Code = op_drv[0];
    assign bus.req1_A       = a_drv[1];
    assign bus.req1_B       = b_drv[1];
    assign bus.req1_OP_Code = op_drv[1];
    assign bus.rsp_ready    = rr;
    assign {bus.alu_NZCV, bus.alu_Result} = alu_model(bus.alu_A, bus.alu_B, bus.alu_OP_Code);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    //------------------------------------------------------------------------
    // Monitor / scoreboard
    //------------------------------------------------------------------------
    initial begin
        logic [1:0] exp_ready;
        logic       grant;
        logic       win;
        logic       hs;
        exp_t       e;
        m_pending = 1'b0;
        m_exec    = 1'b0;
        m_last    = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs",
                    {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_Result, bus.rsp_NZCV,
                     bus.flags_NZCV, bus.alu_A, bus.alu_B, bus.alu_OP_Code, bus.busy}, 64'd0);
                sb.delete();
                m_pending = 1'b0;
                m_exec    = 1'b0;
                m_last    = 1'b1;
            end else begin
                exp_ready = 2'b00;
                grant     = 1'b0;
                win       = 1'b0;
                if (!m_pending && (bus.req_valid != 2'b00)) begin
                    win            = winner(bus.req_valid, m_last);
                    exp_ready[win] = 1'b1;
                    grant          = 1'b1;
                end
                if (bus.req_ready != 2'b00) grant_log.push_back(bus.req_ready[1]);
                chk("req_ready", bus.req_ready, exp_ready);
                chk("busy", bus.busy, m_pending);
                chk("rsp_valid", bus.rsp_valid, m_pending && !m_exec);
                if (m_exec) begin
                    if (sb.size() == 0) timeout("sb_empty_exec");
                    else chk("alu_operands", {bus.alu_A, bus.alu_B, bus.alu_OP_Code},
                             {sb[0].a, sb[0].b, sb[0].op});
                end
                hs = 1'b0;
                if (bus.rsp_valid && m_pending && !m_exec) begin
                    if (sb.size() == 0) begin
                        timeout("sb_empty_resp");
                    end else begin
                        chk("rsp_id", bus.rsp_id, sb[0].id);
                        chk("rsp_Result", bus.rsp_Result, sb[0].res);
                        chk("rsp_NZCV", bus.rsp_NZCV, sb[0].nzcv);
                        chk("flags_NZCV", bus.flags_NZCV, sb[0].nzcv);
                    end
                    hs = bus.rsp_ready;
                end
                if (grant) begin
                    e.id  = win;
                    e.a   = a_drv[win];
                    e.b   = b_drv[win];
                    e.op  = op_drv[win];
                    {e.nzcv, e.res} = alu_model(e.a, e.b, e.op);
                    sb.push_back(e);
                    m_last    = win;
                    m_pending = 1'b1;
                    m_exec    = 1'b1;
                end else if (m_exec) begin
                    m_exec = 1'b0;
                end else if (hs) begin
                    rsp_log.push_back('{id: bus.rsp_id, nzcv: bus.rsp_NZCV, res: bus.rsp_Result});
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_pending = 1'b0;
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Requester driver: issues n operations, holds each until accepted.
    //------------------------------------------------------------------------
    task automatic run_req(input int id, input int n, input int gapmax, input bit rnd,
                           input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        for (int k = 0; k < n; k++) begin
            int gap;
            bit got;
            gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            if (gap > 0) begin
                v_drv[id] = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            a_drv[id]  = rnd ? 8'($urandom) : a;
            b_drv[id]  = rnd ? 8'($urandom) : b;
            op_drv[id] = rnd ? 3'($urandom_range(0, 5)) : op;
            v_drv[id]  = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                got = bus.req_ready[id];
            end
            if (!got) timeout("req_accept");
            @(posedge clk);
            #1;
        end
        v_drv[id] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = !m_pending && (bus.req_valid == 2'b00);
        end
        if (!ok) timeout("drain");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_immediate",
            {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_Result, bus.rsp_NZCV,
             bus.flags_NZCV, bus.alu_A, bus.alu_B, bus.alu_OP_Code, bus.busy}, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    //------------------------------------------------------------------------
    // Main sequence
    //------------------------------------------------------------------------
    initial begin
        logic exp_order [6];
        bit   done;
        bit   seen;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rr     = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v_drv[i]  = 1'b0;
            a_drv[i]  = 8'h00;
            b_drv[i]  = 8'h00;
            op_drv[i] = 3'd0;
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: ADD 0xE4 + 0xA2
        rr = 1'b1;
        run_req(0, 1, 0, 1'b0, 8'hE4, 8'hA2, 3'd0);
        drain();
        if (rsp_log.size() != 1) begin
            timeout("single_rsp_count");
        end else begin
            chk("single_id", rsp_log[0].id, 1'b0);
            chk("single_result", rsp_log[0].res, 8'h86);
            chk("single_nzcv", rsp_log[0].nzcv, 4'b1010);
        end
        chk("single_flags", bus.flags_NZCV, 4'b1010);

        // Tie: both requesters continuously valid, three operations each
        do_reset();
        rsp_log.delete();
        grant_log.delete();
        fork
            run_req(0, 3, 0, 1'b0, 8'hE6, 8'h2C, 3'd2);
            run_req(1, 3, 0, 1'b0, 8'hBC, 8'h12, 3'd3);
        join
        drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        if (grant_log.size() != 6 || rsp_log.size() != 6) begin
            timeout("tie_count");
        end else begin
            for (int i = 0; i < 6; i++) begin
                chk("tie_grant_order", grant_log[i], exp_order[i]);
                chk("tie_rsp_id", rsp_log[i].id, exp_order[i]);
                chk("tie_result", rsp_log[i].res, exp_order[i] ? 8'hBE : 8'h24);
            end
        end

        // Backpressure: response held 5 cycles while requester 1 waits
        rr = 1'b0;
        fork
            run_req(0, 1, 0, 1'b0, 8'h55, 8'h0F, 3'd1);
            run_req(1, 1, 0, 1'b0, 8'h33, 8'h44, 3'd4);
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = bus.rsp_valid;
                end
                if (!seen) timeout("stall_rsp_valid");
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid_busy", {bus.rsp_valid, bus.busy, bus.req_ready}, 4'b1100);
                end
                @(posedge clk);
                #1;
                rr = 1'b1;
            end
        join
        drain();

        // Reset while in EXEC
        fork
            run_req(0, 1, 0, 1'b0, 8'h10, 8'h20, 3'd0);
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = bus.req_ready[0];
                end
                if (!seen) timeout("exec_grant");
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("reset_mid_exec",
                    {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_Result, bus.rsp_NZCV,
                     bus.flags_NZCV, bus.alu_A, bus.alu_B, bus.alu_OP_Code, bus.busy}, 64'd0);
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
        join
        rsp_log.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_log.size(), 0);
        grant_log.delete();
        fork
            run_req(0, 1, 0, 1'b1, 8'h00, 8'h00, 3'd0);
            run_req(1, 1, 0, 1'b1, 8'h00, 8'h00, 3'd0);
        join
        drain();
        if (grant_log.size() == 0) timeout("post_reset_grant");
        else chk("post_reset_first_grant", grant_log[0], 1'b0);

        // Randomized traffic with random backpressure
        fork
            begin
                fork
                    run_req(0, 25, 3, 1'b1, 8'h00, 8'h00, 3'd0);
                    run_req(1, 25, 3, 1'b1, 8'h00, 8'h00, 3'd0);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    rr = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rr = 1'b1;
        drain();
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (checks %0d, failures %0d)", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL match the ALU datapath width.
REQ-002 Parameter OP_W, default 3, ALU opcode width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion SHALL take effect immediately, deassertion synchronous to clk.
REQ-005 req_valid  input  2  per-requester request valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-006 req_ready  output  2  per-requester accept strobe; at most one bit high in any cycle.
REQ-007 req0_A, req0_B / req1_A, req1_B  input  DATA_W  operands per requester.
REQ-008 req0_OP_Code / req1_OP_Code  input  OP_W  ALU opcode per requester.
REQ-009 alu_A, alu_B  output  DATA_W, alu_OP_Code  output  OP_W  registered drive to the shared ALU.
REQ-010 alu_Result  input  DATA_W, alu_NZCV  input  4  combinational ALU outputs.
REQ-011 rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1 (granted requester); rsp_Result  output  DATA_W; rsp_NZCV  output  4.
REQ-012 flags_NZCV  output  4  NZCV of the most recently completed operation.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; encoding free.
REQ-015 IDLE: if any req_valid bit set, SHALL grant one requester, pulse its req_ready for that cycle, latch its A/B/OP_Code and id into operand registers, move to EXEC; otherwise remain in IDLE.
REQ-016 req_ready SHALL be asserted only in IDLE and only for a requester whose req_valid is high; requesters hold req_valid and operands stable until accepted.
REQ-017 alu_A/alu_B/alu_OP_Code SHALL always reflect the operand registers; they change only on a grant.
REQ-018 EXEC lasts exactly one cycle; at its closing edge alu_Result and alu_NZCV SHALL be captured into rsp_Result, rsp_NZCV and flags_NZCV; next state RESP.
REQ-019 RESP: rsp_valid SHALL be high; rsp_id/rsp_Result/rsp_NZCV SHALL be stable; on rsp_valid && rsp_ready, return to IDLE the next cycle.
REQ-020 Latency: grant at edge N -> rsp_valid high from edge N+2; minimum spacing between grants 3 cycles.
REQ-021 rsp_ready while rsp_valid is low SHALL be ignored.
REQ-022 Round-robin arbitration: a last_grant bit SHALL record the granted id; with both requests valid the requester not equal to last_grant wins; a single valid requester wins regardless of last_grant.
REQ-023 New requests arriving in EXEC/RESP SHALL wait; no request is dropped or reordered per requester.
REQ-024 The block SHALL NOT modify Result or NZCV values; widths pass through unchanged.

Reset
REQ-025 On rst_n low: state IDLE; req_ready 0; rsp_valid 0; rsp_id 0; rsp_Result 0; rsp_NZCV 0; flags_NZCV 0; alu_A/alu_B/alu_OP_Code 0; busy 0; last_grant 1 (requester 0 wins first tie).
REQ-026 Reset asserted in EXEC or RESP SHALL abandon the operation; no response is produced for it after reset release.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win when both are valid and last_grant is unused; when undefined, round-robin per REQ-022.

Verification
REQ-028 Single request: req0 ADD (000) A=0xE4 B=0xA2 -> req_ready=01 one cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_Result=0x86, rsp_NZCV=alu_NZCV (C set), flags_NZCV equal.
REQ-029 Tie, round-robin: both valid continuously, req0 AND 0xE6&0x2C, req1 OR 0xBC|0x12 -> grants 0,1,0,1; results 0x24 and 0xBE alternate with matching rsp_id.
REQ-030 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid and data stable, busy=1, no req_ready pulse until after handshake.
REQ-031 Reset mid-EXEC: rst_n low during EXEC -> all outputs zero immediately, no rsp_valid after release, next grant goes to requester 0.
REQ-032 With ALU_ARB_FIXED_PRIO_EN: both valid for 3 operations -> all three grants to requester 0, requester 1 granted only when req_valid[0] drops.
